// File: rtl/cosim_step_sched.sv
// Commit-stream scheduler: per-hart retire FIFOs merged round-robin into one
// registered step stream (hart id + sequence tagged) for the co-sim checker.
module cosim_step_sched #(
  parameter int NUM_HART   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_HART-1:0]         cmt_valid,
  output logic [NUM_HART-1:0]         cmt_ready,
  input  logic [NUM_HART*XLEN-1:0]    cmt_pc,
  input  logic [NUM_HART*32-1:0]      cmt_ir,
  input  logic [NUM_HART*2-1:0]       cmt_prv,
  input  logic [NUM_HART-1:0]         cmt_trap,
  input  logic [NUM_HART*32-1:0]      cmt_irq,
  output logic                        step_valid,
  input  logic                        step_ready,
  output logic [$clog2(NUM_HART)-1:0] step_pid,
  output logic [XLEN-1:0]             step_pc,
  output logic [31:0]                 step_ir,
  output logic [1:0]                  step_prv,
  output logic                        step_trap,
  output logic [31:0]                 step_irq,
  output logic [15:0]                 step_seq,
  input  logic                        chk_halt,
  input  logic                        sched_flush
);
  localparam int PID_W = $clog2(NUM_HART);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic [1:0]      prv;
    logic            trap;
    logic [31:0]     irq;
  } rec_t;

  rec_t                head_rec [NUM_HART];
  logic [NUM_HART-1:0] push;
  logic [NUM_HART-1:0] pop;
  logic [NUM_HART-1:0] nonempty;

  logic             valid_q, valid_d;
  logic [PID_W-1:0] pid_q, pid_d;
  logic [PID_W-1:0] rr_q, rr_d;
  rec_t             rec_q, rec_d;
  logic [15:0]      seq_q, seq_d;

  logic             grant_found;
  logic [PID_W-1:0] grant_idx;
  logic             load;

  for (genvar gi = 0; gi < NUM_HART; gi++) begin : g_fifo
    rec_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;
    rec_t             in_rec;

    assign in_rec = '{pc:   cmt_pc[gi*XLEN +: XLEN],
                      ir:   cmt_ir[gi*32 +: 32],
                      prv:  cmt_prv[gi*2 +: 2],
                      trap: cmt_trap[gi],
                      irq:  cmt_irq[gi*32 +: 32]};

    // A flush in the same cycle discards the incoming record as well.
    assign push[gi]      = cmt_valid[gi] && ready_q && !sched_flush;
    assign nonempty[gi]  = (count_q != '0);
    assign head_rec[gi]  = mem_q[rd_ptr_q];
    assign cmt_ready[gi] = ready_q;
    assign count_d = sched_flush ? '0
                   : count_q + CNT_W'(push[gi]) - CNT_W'(pop[gi]);

    always_ff @(posedge clk) begin
      if (push[gi]) mem_q[wr_ptr_q] <= in_rec;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ready_q  <= 1'b0;
      end else begin
        count_q <= count_d;
        ready_q <= (count_d < CNT_W'(FIFO_DEPTH));
        if (sched_flush) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          if (push[gi]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          if (pop[gi])  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  // Round-robin search begins one past the last granted hart.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_HART; k++) begin
      cand = (int'(rr_q) + k) % NUM_HART;
      if (!grant_found && nonempty[PID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PID_W'(cand);
      end
    end
  end

  assign load = (!valid_q || step_ready) && !chk_halt && grant_found && !sched_flush;

  always_comb begin
    pop = '0;
    if (load) pop = NUM_HART'(1) << grant_idx;
  end

  always_comb begin
    valid_d = valid_q;
    pid_d   = pid_q;
    rec_d   = rec_q;
    rr_d    = rr_q;
    seq_d   = seq_q;
    if (sched_flush) begin
      valid_d = 1'b0;
      rr_d    = PID_W'(NUM_HART - 1);
    end else begin
      if (valid_q && step_ready) seq_d = seq_q + 16'd1;
      if (load) begin
        valid_d = 1'b1;
        pid_d   = grant_idx;
        rec_d   = head_rec[grant_idx];
        rr_d    = grant_idx;
      end else if (step_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pid_q   <= '0;
      rec_q   <= '0;
      rr_q    <= PID_W'(NUM_HART - 1);
      seq_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pid_q   <= pid_d;
      rec_q   <= rec_d;
      rr_q    <= rr_d;
      seq_q   <= seq_d;
    end
  end

  assign step_valid = valid_q;
  assign step_pid   = pid_q;
  assign step_pc    = rec_q.pc;
  assign step_ir    = rec_q.ir;
  assign step_prv   = rec_q.prv;
  assign step_trap  = rec_q.trap;
  assign step_irq   = rec_q.irq;
  assign step_seq   = seq_q;
endmodule

// File: tb/tb_cosim_step_sched.sv
// Directed bench for cosim_step_sched: stimulus pushes expected records into a
// queue, a forked monitor pops and compares on every output handshake.
module tb_cosim_step_sched;
  localparam int NH = 4;
  localparam int XL = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NH-1:0]   cmt_valid;
  logic [NH-1:0]   cmt_ready;
  logic [NH*XL-1:0] cmt_pc;
  logic [NH*32-1:0] cmt_ir;
  logic [NH*2-1:0] cmt_prv;
  logic [NH-1:0]   cmt_trap;
  logic [NH*32-1:0] cmt_irq;
  logic            step_valid;
  logic            step_ready;
  logic [1:0]      step_pid;
  logic [XL-1:0]   step_pc;
  logic [31:0]     step_ir;
  logic [1:0]      step_prv;
  logic            step_trap;
  logic [31:0]     step_irq;
  logic [15:0]     step_seq;
  logic            chk_halt;
  logic            sched_flush;

  always #5 clk = ~clk;

  cosim_step_sched #(.NUM_HART(NH), .FIFO_DEPTH(4), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc), .cmt_ir(cmt_ir),
    .cmt_prv(cmt_prv), .cmt_trap(cmt_trap), .cmt_irq(cmt_irq),
    .step_valid(step_valid), .step_ready(step_ready), .step_pid(step_pid),
    .step_pc(step_pc), .step_ir(step_ir), .step_prv(step_prv), .step_trap(step_trap),
    .step_irq(step_irq), .step_seq(step_seq),
    .chk_halt(chk_halt), .sched_flush(sched_flush)
  );

  typedef struct packed {
    logic [1:0]  pid;
    logic [63:0] pc;
    logic [31:0] ir;
    logic [1:0]  prv;
    logic        trap;
    logic [31:0] irq;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        cur, snap, e;
  logic        held;
  logic [15:0] hs_count;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input logic [63:0] pc, input logic [31:0] ir,
                       input logic [1:0] prv, input logic trap, input logic [31:0] irq,
                       input bit expect_out);
    cmt_valid[h]         = 1'b1;
    cmt_pc[h*64 +: 64]   = pc;
    cmt_ir[h*32 +: 32]   = ir;
    cmt_prv[h*2 +: 2]    = prv;
    cmt_trap[h]          = trap;
    cmt_irq[h*32 +: 32]  = irq;
    if (expect_out) exp_q.push_back('{2'(h), pc, ir, prv, trap, irq});
  endtask

  initial begin
    rst_n = 1'b0; cmt_valid = 4'hF; cmt_pc = '1; cmt_ir = '1; cmt_prv = '1;
    cmt_trap = '1; cmt_irq = '1; step_ready = 1'b0; chk_halt = 1'b0; sched_flush = 1'b0;
    held = 1'b0; hs_count = '0;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst_n === 1'b1) begin
            cur = {step_pid, step_pc, step_ir, step_prv, step_trap, step_irq};
            if (held && step_valid) chk("stable_hold", 160'(cur), 160'(snap));
            if (step_valid && step_ready) begin
              if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: got pid=%0d pc=%0h expected no record", step_pid, step_pc);
              end else begin
                e = exp_q.pop_front();
                chk("out_rec", 160'(cur), 160'(e));
                chk("out_seq", 160'(step_seq), 160'(hs_count));
              end
              hs_count++;
            end
            held = step_valid && !step_ready;
            snap = cur;
          end else begin
            held = 1'b0;
            hs_count = '0;
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
      end
    join_none

    // Reset with all harts trying to push
    repeat (3) tick();
    chk("rst_valid", 160'(step_valid), 160'(0));
    chk("rst_seq", 160'(step_seq), 160'(0));
    chk("rst_ready", 160'(cmt_ready), 160'(0));
    chk("rst_pc", 160'(step_pc), 160'(0));
    rst_n = 1'b1; cmt_valid = '0;
    tick();
    chk("rel_ready", 160'(cmt_ready), 160'(4'hF));
    chk("rel_valid0", 160'(step_valid), 160'(0));
    tick();
    chk("rel_valid1", 160'(step_valid), 160'(0));

    // Single record through hart 2
    drive(2, 64'h8000_0000, 32'h0000_0013, 2'd3, 1'b0, 32'h0, 1'b1);
    tick();
    cmt_valid = '0;
    chk("single_lat1", 160'(step_valid), 160'(0));
    tick();
    chk("single_lat2", 160'(step_valid), 160'(1));
    chk("single_pid", 160'(step_pid), 160'(2));
    step_ready = 1'b1;
    tick();
    step_ready = 1'b0;
    chk("single_seq", 160'(step_seq), 160'(1));
    chk("single_done", 160'(step_valid), 160'(0));

    // Round-robin: flush parks rr on hart 3, halt holds output during preload
    sched_flush = 1'b1; tick(); sched_flush = 1'b0;
    chk_halt = 1'b1;
    for (int h = 0; h < NH; h++) drive(h, 64'h1000 + 64'(h * 16), 32'h100 + 32'(h), 2'd0, 1'b0, 32'(h), 1'b1);
    tick();
    for (int h = 0; h < NH; h++) drive(h, 64'h1004 + 64'(h * 16), 32'h200 + 32'(h), 2'd1, 1'b1, 32'(h), 1'b1);
    tick();
    cmt_valid = '0;
    chk("rr_halted", 160'(step_valid), 160'(0));
    step_ready = 1'b1; chk_halt = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("rr_valid", 160'(step_valid), 160'(1));
      chk("rr_pid", 160'(step_pid), 160'(i % 4));
      tick();
    end
    chk("rr_drained", 160'(step_valid), 160'(0));
    step_ready = 1'b0;

    // Backpressure: hart 0 record parked on the output, hart 1 FIFO fills
    drive(0, 64'h4000, 32'h0000_0073, 2'd3, 1'b0, 32'h8, 1'b1);
    tick();
    cmt_valid = '0;
    tick();
    chk("bp_valid", 160'(step_valid), 160'(1));
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", 160'(cmt_ready[1]), 160'(k < 4));
      chk("bp_hold_pc", 160'(step_pc), 160'(64'h4000));
      drive(1, 64'h2000 + 64'(k * 4), 32'h300 + 32'(k), 2'd1, 1'b0, 32'h0, k < 4);
      tick();
    end
    cmt_valid = '0;
    chk("bp_full", 160'(cmt_ready[1]), 160'(0));
    step_ready = 1'b1;
    tick();
    step_ready = 1'b0;
    chk("bp_freed", 160'(cmt_ready[1]), 160'(1));
    step_ready = 1'b1;
    repeat (4) tick();
    step_ready = 1'b0;
    chk("bp_drained", 160'(step_valid), 160'(0));

    // Halt with a record in the output register (rr currently hart 1)
    drive(2, 64'h5000, 32'h500, 2'd0, 1'b0, 32'h1, 1'b1);
    drive(3, 64'h6000, 32'h600, 2'd1, 1'b1, 32'h2, 1'b1);
    drive(0, 64'h7000, 32'h700, 2'd3, 1'b0, 32'h3, 1'b1);
    tick();
    cmt_valid = '0;
    tick();
    chk("halt_pre_pid", 160'(step_pid), 160'(2));
    chk_halt = 1'b1; step_ready = 1'b1;
    tick();
    chk("halt_taken", 160'(step_valid), 160'(0));
    repeat (3) begin
      tick();
      chk("halt_idle", 160'(step_valid), 160'(0));
    end
    chk_halt = 1'b0;
    tick();
    chk("resume_valid", 160'(step_valid), 160'(1));
    chk("resume_pid", 160'(step_pid), 160'(3));
    tick();
    tick();
    step_ready = 1'b0;
    chk("halt_drained", 160'(step_valid), 160'(0));

    // Flush with harts 0..2 partly full and a record on the output
    for (int h = 0; h < 3; h++) drive(h, 64'h9000 + 64'(h * 16), 32'h900, 2'd0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int h = 0; h < 3; h++) drive(h, 64'h9004 + 64'(h * 16), 32'h904, 2'd0, 1'b0, 32'h0, 1'b0);
    tick();
    cmt_valid = '0;
    tick();
    chk("fl_pre_valid", 160'(step_valid), 160'(1));
    chk("fl_pre_pid", 160'(step_pid), 160'(1));
    chk("fl_pre_seq", 160'(step_seq), 160'(17));
    sched_flush = 1'b1;
    drive(3, 64'hDEAD, 32'hDEAD, 2'd3, 1'b1, 32'hDEAD, 1'b0);
    tick();
    sched_flush = 1'b0; cmt_valid = '0;
    chk("fl_valid", 160'(step_valid), 160'(0));
    chk("fl_seq", 160'(step_seq), 160'(17));
    chk("fl_ready", 160'(cmt_ready), 160'(4'hF));
    drive(3, 64'hA000, 32'hA00, 2'd1, 1'b0, 32'h55, 1'b1);
    tick();
    cmt_valid = '0;
    tick();
    chk("fl_next_valid", 160'(step_valid), 160'(1));
    chk("fl_next_pid", 160'(step_pid), 160'(3));
    step_ready = 1'b1;
    tick();
    step_ready = 1'b0;
    chk("fl_end_valid", 160'(step_valid), 160'(0));
    chk("fl_end_seq", 160'(step_seq), 160'(18));
    tick();
    chk("sb_empty", 160'(exp_q.size()), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
